// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: RV64I/RV32I decoder feeding a DEPTH-entry queue; macro ILLEGAL_INSN_TRAP_EN adds the illegal port.
// Latency 1 cycle, 1 instr/cycle; all outputs come from the head entry.
// Backpressure: in_ready = queue not full (no pass-through); flush drops queued and same-cycle traffic.
module instruction_decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_wen,
  output logic            mem_to_reg,
  output logic [3:0]      alu_op,
  output logic [2:0]      branch_type,
  output logic            imm_src,
  output logic            pc_src,
  output logic [1:0]      mem_op,
  output logic [1:0]      mem_size,
  output logic [XLEN-1:0] imm,
  output logic            jmp,
`ifdef ILLEGAL_INSN_TRAP_EN
  output logic            illegal,
`endif
  output logic            jalr
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int SHW = $clog2(XLEN);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [3:0] {
    ALU_NO, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SCOMP, ALU_UCOMP,
    ALU_XOR, ALU_SLR, ALU_SAR, ALU_OR, ALU_AND
  } alu_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_wen;
    logic            mem_to_reg;
    logic [3:0]      alu_op;
    logic [2:0]      branch_type;
    logic            imm_src;
    logic            pc_src;
    logic [1:0]      mem_op;
    logic [1:0]      mem_size;
    logic            jmp;
    logic            jalr;
`ifdef ILLEGAL_INSN_TRAP_EN
    logic            illegal;
`endif
  } entry_t;

  entry_t          dec;
  logic            legal;
  logic            writes;
  logic [2:0]      f3;
  logic            push;
  logic            pop;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  entry_t          head;

  assign f3 = in_inst[14:12];

  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    writes = 1'b0;
    case (in_inst[6:0])
      7'b0110011: begin
        dec.rs1 = in_inst[19:15];
        dec.rs2 = in_inst[24:20];
        dec.rd  = in_inst[11:7];
        writes  = 1'b1;
        case ({in_inst[31:25], f3})
          {7'h00, 3'd0}: dec.alu_op = ALU_ADD;
          {7'h00, 3'd1}: dec.alu_op = ALU_SLL;
          {7'h00, 3'd2}: dec.alu_op = ALU_SCOMP;
          {7'h00, 3'd3}: dec.alu_op = ALU_UCOMP;
          {7'h00, 3'd4}: dec.alu_op = ALU_XOR;
          {7'h00, 3'd5}: dec.alu_op = ALU_SLR;
          {7'h00, 3'd6}: dec.alu_op = ALU_OR;
          {7'h00, 3'd7}: dec.alu_op = ALU_AND;
          {7'h20, 3'd0}: dec.alu_op = ALU_SUB;
          {7'h20, 3'd5}: dec.alu_op = ALU_SAR;
          default:       legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec.rs1     = in_inst[19:15];
        dec.rd      = in_inst[11:7];
        dec.imm_src = 1'b1;
        dec.imm     = XLEN'($signed(in_inst[31:20]));
        writes      = 1'b1;
        case (f3)
          3'd0: dec.alu_op = ALU_ADD;
          3'd2: dec.alu_op = ALU_SCOMP;
          3'd3: dec.alu_op = ALU_UCOMP;
          3'd4: dec.alu_op = ALU_XOR;
          3'd6: dec.alu_op = ALU_OR;
          3'd7: dec.alu_op = ALU_AND;
          3'd1: if (in_inst[31:20+SHW] == '0) dec.alu_op = ALU_SLL; else legal = 1'b0;
          default: begin
            // Bits above the shamt must be 0 (SRLI) or 0100..0 (SRAI).
            if (in_inst[31:20+SHW] == '0) dec.alu_op = ALU_SLR;
            else if (!in_inst[31] && in_inst[30] && in_inst[29:20+SHW] == '0) dec.alu_op = ALU_SAR;
            else legal = 1'b0;
          end
        endcase
      end
      7'b0000011: begin
        dec.rs1        = in_inst[19:15];
        dec.rd         = in_inst[11:7];
        dec.imm_src    = 1'b1;
        dec.imm        = XLEN'($signed(in_inst[31:20]));
        dec.alu_op     = ALU_ADD;
        dec.mem_to_reg = 1'b1;
        dec.mem_op     = f3[2] ? 2'd2 : 2'd1;
        dec.mem_size   = f3[1:0];
        writes         = 1'b1;
        legal          = !(f3 == 3'd7 || (XLEN == 32 && (f3 == 3'd3 || f3 == 3'd6)));
      end
      7'b0100011: begin
        dec.rs1      = in_inst[19:15];
        dec.rs2      = in_inst[24:20];
        dec.imm_src  = 1'b1;
        dec.imm      = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
        dec.alu_op   = ALU_ADD;
        dec.mem_op   = 2'd3;
        dec.mem_size = f3[1:0];
        legal        = !f3[2] && !(XLEN == 32 && f3 == 3'd3);
      end
      7'b0110111, 7'b0010111: begin
        dec.rd      = in_inst[11:7];
        dec.imm_src = 1'b1;
        dec.pc_src  = in_inst[5] == 1'b0;
        dec.imm     = XLEN'($signed({in_inst[31:12], 12'b0}));
        dec.alu_op  = ALU_ADD;
        writes      = 1'b1;
      end
      7'b1101111: begin
        dec.rd      = in_inst[11:7];
        dec.imm_src = 1'b1;
        dec.pc_src  = 1'b1;
        dec.imm     = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
        dec.alu_op  = ALU_ADD;
        dec.jmp     = 1'b1;
        writes      = 1'b1;
      end
      7'b1100111: begin
        dec.rs1     = in_inst[19:15];
        dec.rd      = in_inst[11:7];
        dec.imm_src = 1'b1;
        dec.imm     = XLEN'($signed(in_inst[31:20]));
        dec.alu_op  = ALU_ADD;
        dec.jmp     = 1'b1;
        dec.jalr    = 1'b1;
        writes      = 1'b1;
        legal       = (f3 == 3'd0);
      end
      7'b1100011: begin
        dec.rs1    = in_inst[19:15];
        dec.rs2    = in_inst[24:20];
        dec.imm    = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
        dec.alu_op = (f3 == 3'd4 || f3 == 3'd5) ? ALU_SCOMP : ALU_UCOMP;
        case (f3)
          3'd0:    dec.branch_type = 3'd1;
          3'd1:    dec.branch_type = 3'd2;
          3'd4:    dec.branch_type = 3'd3;
          3'd5:    dec.branch_type = 3'd4;
          3'd6:    dec.branch_type = 3'd5;
          3'd7:    dec.branch_type = 3'd6;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    dec.reg_wen = writes && (dec.rd != 5'd0);
    if (!legal) dec = '0;
    dec.pc = in_pc;
`ifdef ILLEGAL_INSN_TRAP_EN
    dec.illegal = !legal;
`endif
  end

  assign in_ready  = (cnt_q != FULL);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_pc      = head.pc;
  assign rs1         = head.rs1;
  assign rs2         = head.rs2;
  assign rd          = head.rd;
  assign reg_wen     = head.reg_wen;
  assign mem_to_reg  = head.mem_to_reg;
  assign alu_op      = head.alu_op;
  assign branch_type = head.branch_type;
  assign imm_src     = head.imm_src;
  assign pc_src      = head.pc_src;
  assign mem_op      = head.mem_op;
  assign mem_size    = head.mem_size;
  assign imm         = head.imm;
  assign jmp         = head.jmp;
  assign jalr        = head.jalr;
`ifdef ILLEGAL_INSN_TRAP_EN
  assign illegal     = head.illegal;
`endif
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed steps then random traffic, checked against a queue-level model.
module tb_instruction_decode_stage;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_wen, mem_to_reg, imm_src, pc_src, jmp, jalr;
  logic [3:0]  alu_op;
  logic [2:0]  branch_type;
  logic [1:0]  mem_op, mem_size;
  logic [63:0] imm;
`ifdef ILLEGAL_INSN_TRAP_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_wen, mem_to_reg;
    logic [3:0]  alu_op;
    logic [2:0]  br;
    logic        imm_src, pc_src;
    logic [1:0]  mem_op, mem_size;
    logic        jmp, jalr, illegal;
  } exp_t;

  exp_t q[$];

  instruction_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_wen(reg_wen), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .branch_type(branch_type), .imm_src(imm_src), .pc_src(pc_src),
    .mem_op(mem_op), .mem_size(mem_size), .imm(imm), .jmp(jmp),
`ifdef ILLEGAL_INSN_TRAP_EN
    .illegal(illegal),
`endif
    .jalr(jalr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the ISA rules with signed arithmetic on the raw word.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
    exp_t   e = '0;
    bit     ok = 1'b0;
    bit     wr = 1'b0;
    int     f3 = int'(i[14:12]);
    longint s = longint'($signed(i));
    int     op_alu[8] = '{1, 3, 4, 5, 6, 7, 9, 10};
    int     br_code[8] = '{1, 2, 0, 0, 3, 4, 5, 6};
    case (i[6:0])
      7'h33: begin
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; wr = 1;
        if (i[31:25] == 7'h00) begin ok = 1; e.alu_op = 4'(op_alu[f3]); end
        else if (i[31:25] == 7'h20 && (f3 == 0 || f3 == 5)) begin
          ok = 1; e.alu_op = (f3 == 0) ? 4'd2 : 4'd8;
        end
      end
      7'h13: begin
        e.rs1 = i[19:15]; e.rd = i[11:7]; wr = 1; e.imm_src = 1; e.imm = s >>> 20;
        if (f3 == 1) ok = (i[31:26] == 6'd0);
        else if (f3 == 5) ok = (i[31:26] == 6'd0 || i[31:26] == 6'b010000);
        else ok = 1;
        e.alu_op = (f3 == 5 && i[30]) ? 4'd8 : 4'(op_alu[f3]);
      end
      7'h03: begin
        e.rs1 = i[19:15]; e.rd = i[11:7]; wr = 1; e.imm_src = 1; e.imm = s >>> 20;
        e.alu_op = 1; e.mem_to_reg = 1; ok = (f3 != 7);
        e.mem_op = (f3 >= 4) ? 2'd2 : 2'd1; e.mem_size = 2'(f3 % 4);
      end
      7'h23: begin
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm_src = 1; e.alu_op = 1;
        ok = (f3 < 4); e.mem_op = 3; e.mem_size = 2'(f3 % 4);
        e.imm = ((s >>> 25) * 32) + longint'(i[11:7]);
      end
      7'h37, 7'h17: begin
        e.rd = i[11:7]; wr = 1; ok = 1; e.imm_src = 1; e.alu_op = 1;
        e.pc_src = (i[6:0] == 7'h17); e.imm = (s >>> 12) * 4096;
      end
      7'h6F: begin
        e.rd = i[11:7]; wr = 1; ok = 1; e.imm_src = 1; e.pc_src = 1; e.alu_op = 1; e.jmp = 1;
        e.imm = (s >>> 31) * 1048576 + longint'(i[19:12]) * 4096
              + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
      7'h67: begin
        e.rd = i[11:7]; e.rs1 = i[19:15]; wr = 1; ok = (f3 == 0);
        e.imm_src = 1; e.alu_op = 1; e.jmp = 1; e.jalr = 1; e.imm = s >>> 20;
      end
      7'h63: begin
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; ok = (f3 != 2 && f3 != 3);
        e.br = 3'(br_code[f3]); e.alu_op = (f3 == 4 || f3 == 5) ? 4'd4 : 4'd5;
        e.imm = (s >>> 31) * 4096 + longint'(i[7]) * 2048
              + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      end
      default: ok = 0;
    endcase
    e.reg_wen = wr && (e.rd != 0);
    if (!ok) e = '0;
    e.pc = pc;
    e.illegal = !ok;
    return e;
  endfunction

  task automatic check_head(input exp_t e);
    chk("out_pc", out_pc, e.pc);
    chk("imm", imm, e.imm);
    chk("rs1", rs1, e.rs1);
    chk("rs2", rs2, e.rs2);
    chk("rd", rd, e.rd);
    chk("reg_wen", reg_wen, e.reg_wen);
    chk("mem_to_reg", mem_to_reg, e.mem_to_reg);
    chk("alu_op", alu_op, e.alu_op);
    chk("branch_type", branch_type, e.br);
    chk("imm_src", imm_src, e.imm_src);
    chk("pc_src", pc_src, e.pc_src);
    chk("mem_op", mem_op, e.mem_op);
    chk("mem_size", mem_size, e.mem_size);
    chk("jmp", jmp, e.jmp);
    chk("jalr", jalr, e.jalr);
`ifdef ILLEGAL_INSN_TRAP_EN
    chk("illegal", illegal, e.illegal);
`endif
  endtask

  // Check the current state, take one clock edge, then advance the model queue.
  task automatic cycle();
    bit do_push, do_pop;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() != DEPTH);
    if (q.size() != 0) check_head(q[0]);
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = out_ready && (q.size() != 0);
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(model(in_inst, in_pc));
    end
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    cycle();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [6:0]  opcs[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h0B};
    logic [31:0] w = $urandom;
    w[6:0] = opcs[$urandom_range(9)];
    if ($urandom_range(3) != 0) w[31:26] = ($urandom_range(1) != 0) ? 6'h10 : 6'h00;
    return w;
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    #11;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", imm, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_reg_wen", reg_wen, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push_one(32'hFFF00093, 64'h8000_0000);
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", rd, 1);
    chk("addi_alu", alu_op, 1);
    chk("addi_imm_src", imm_src, 1);
    chk("addi_reg_wen", reg_wen, 1);
    chk("addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_pc", out_pc, 64'h8000_0000);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    push_one(32'hFE208EE3, 64'h8000_0004);
    chk("beq_br", branch_type, 1);
    chk("beq_alu", alu_op, 5);
    chk("beq_rs1", rs1, 1);
    chk("beq_rs2", rs2, 2);
    chk("beq_reg_wen", reg_wen, 0);
    chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    push_one(32'h800002B7, 64'h8000_0008);
    chk("lui_imm", imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_rd", rd, 5);
    chk("lui_imm_src", imm_src, 1);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    // Back-pressure: A and B fill the queue, C must wait.
    in_valid = 1'b1;
    in_inst = 32'h00100113; in_pc = 64'h100; cycle();
    in_inst = 32'h00200193; in_pc = 64'h104; cycle();
    chk("bp_full", in_ready, 0);
    in_inst = 32'h00300213; in_pc = 64'h108; cycle();
    chk("bp_head_a", out_pc, 64'h100);
    out_ready = 1'b1; cycle();
    chk("bp_head_b", out_pc, 64'h104);
    cycle();
    in_valid = 1'b0;
    chk("bp_head_c", out_pc, 64'h108);
    cycle();
    chk("bp_drained_valid", out_valid, 0);
    chk("bp_drained_ready", in_ready, 1);
    cycle();

    // Flush with a push in the same cycle.
    out_ready = 1'b0;
    push_one(32'h00A00293, 64'h200);
    push_one(32'h00B00313, 64'h204);
    in_valid = 1'b1; in_inst = 32'h00C00393; in_pc = 64'h208; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    cycle();

    push_one(32'h0000_0000, 64'h300);
    chk("bad_reg_wen", reg_wen, 0);
    chk("bad_mem_op", mem_op, 0);
    chk("bad_jmp", jmp, 0);
`ifdef ILLEGAL_INSN_TRAP_EN
    chk("bad_illegal", illegal, 1);
`endif
    out_ready = 1'b1; cycle(); out_ready = 1'b0;

    // Reset mid-stream discards queued entries at once.
    push_one(32'h00100413, 64'h400);
    push_one(32'h00200493, 64'h404);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    cycle();

    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_inst   = gen_inst();
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(19) == 0);
      cycle();
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < DEPTH + 2; n++) cycle();
    chk("final_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
